// File: rtl/rng_lfsr_gen_if.sv
// Request/result bundle for the LFSR random word generator.
interface rng_lfsr_gen_if;
   logic        start_i;
   logic [1:0]  seed_sel_i;
   logic [15:0] rnd_o;
   logic        valid_o;
   logic        busy_o;

   // Requester side
   modport master (
      output start_i,
      output seed_sel_i,
      input  rnd_o,
      input  valid_o,
      input  busy_o
   );

   // Generator side
   modport slave (
      input  start_i,
      input  seed_sel_i,
      output rnd_o,
      output valid_o,
      output busy_o
   );
endinterface

// File: rtl/rng_lfsr_gen.sv
// 16-bit Fibonacci LFSR random word generator. Each request reseeds the LFSR with
// SEED[sel] XOR the previous word, runs ITER_CNT shifts, then publishes the result.
module rng_lfsr_gen #(
   parameter logic [15:0] SEED_0   = 16'hACE1,
   parameter logic [15:0] SEED_1   = 16'h1D87,
   parameter logic [15:0] SEED_2   = 16'hB400,
   parameter logic [15:0] SEED_3   = 16'h5A5A,
   parameter int unsigned ITER_CNT = 16
) (
   input logic           clk_i,
   input logic           rst_i,
   rng_lfsr_gen_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   // Counter value seen on the edge that performs the final shift
   localparam logic [7:0] LastCnt = 8'(ITER_CNT - 1);

   state_e      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] rnd_q, rnd_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] seed_word;
   logic [15:0] load_word;
   logic [15:0] lfsr_shift;
   logic        last_shift;

   // Taps 16,14,13,11: maximal length, so a nonzero seed never reaches zero
   assign lfsr_shift = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign last_shift = (cnt_q == LastCnt);

   // Seed selection from the latched index and lock-up avoidance on load
   always_comb begin
      seed_word = SEED_0;
      unique case (sel_q)
         2'b00: seed_word = SEED_0;
         2'b01: seed_word = SEED_1;
         2'b10: seed_word = SEED_2;
         2'b11: seed_word = SEED_3;
         default: seed_word = SEED_0;
      endcase
      load_word = seed_word ^ rnd_q;
      if (load_word == 16'h0000) begin
         load_word = 16'hACE1;
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start_i only matters in idle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start_i) state_d = StLoad;
         StLoad:  state_d = StShift;
         StShift: if (last_shift) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; rnd_o comes straight from its register
   always_comb begin
      bus.valid_o = (state_q == StDone);
      bus.busy_o  = (state_q != StIdle);
      bus.rnd_o   = rnd_q;
   end

   // Datapath next-state: latch sel, load, shift and capture the result
   always_comb begin
      sel_d  = sel_q;
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      rnd_d  = rnd_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start_i) sel_d = bus.seed_sel_i;
         end
         StLoad: begin
            lfsr_d = load_word;
            cnt_d  = 8'd0;
         end
         StShift: begin
            lfsr_d = lfsr_shift;
            cnt_d  = cnt_q + 8'd1;
            if (last_shift) rnd_d = lfsr_shift;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_q  <= 2'b00;
         lfsr_q <= 16'h0000;
         cnt_q  <= 8'd0;
         rnd_q  <= 16'h0000;
      end else begin
         sel_q  <= sel_d;
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
         rnd_q  <= rnd_d;
      end
   end

endmodule

// File: tb/tb_rng_lfsr_gen.sv
// Directed bench: a short-run instance (ITER_CNT=1) with hand-computed words and a
// default instance checked against a small LFSR model for timing and reseeding.
module tb_rng_lfsr_gen;

   logic clk_i;
   logic rst_i;
   int   total = 0;
   int   bad   = 0;

   rng_lfsr_gen_if a_if ();
   rng_lfsr_gen_if d_if ();

   rng_lfsr_gen #(
      .SEED_0   (16'h0001),
      .SEED_1   (16'h0002),
      .ITER_CNT (1)
   ) dut_a (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (a_if)
   );

   rng_lfsr_gen dut_d (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (d_if)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] seed, input logic [15:0] prev,
                                         input int n);
      logic [15:0] v;
      v = seed ^ prev;
      if (v == 16'h0000) v = 16'hACE1;
      for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      return v;
   endfunction

   // One request on the ITER_CNT=1 instance; also raises start in the DONE cycle
   task automatic run_a(input string tag, input logic [1:0] sel, input logic [15:0] exp);
      a_if.start_i    = 1'b1;
      a_if.seed_sel_i = sel;
      step();
      a_if.start_i = 1'b0;
      chk1({tag, "_load_busy"}, a_if.busy_o, 1'b1);
      chk1({tag, "_load_valid"}, a_if.valid_o, 1'b0);
      step();
      chk1({tag, "_shift_valid"}, a_if.valid_o, 1'b0);
      step();
      chk1({tag, "_done_valid"}, a_if.valid_o, 1'b1);
      chk16({tag, "_rnd"}, a_if.rnd_o, exp);
      a_if.start_i = 1'b1;
      step();
      a_if.start_i = 1'b0;
      chk1({tag, "_idle_valid"}, a_if.valid_o, 1'b0);
      step();
      chk1({tag, "_done_start_ignored"}, a_if.busy_o, 1'b0);
      chk16({tag, "_rnd_hold"}, a_if.rnd_o, exp);
   endtask

   // One request on the default instance; seed_sel_i switches to sel_mid mid-run
   task automatic run_d(input string tag, input logic [1:0] sel, input logic [1:0] sel_mid,
                        input logic [15:0] exp);
      int n;
      d_if.start_i    = 1'b1;
      d_if.seed_sel_i = sel;
      step();
      d_if.start_i = 1'b0;
      n = 0;
      do begin
         step();
         n++;
         if (n == 3) d_if.seed_sel_i = sel_mid;
      end while (!d_if.valid_o && n < 40);
      chkn({tag, "_latency"}, n, 17);
      chk16({tag, "_rnd"}, d_if.rnd_o, exp);
      step();
      chk1({tag, "_pulse_end"}, d_if.valid_o, 1'b0);
   endtask

   initial begin
      logic [15:0] prev_d;
      logic [15:0] exp_w;
      int          n;
      int          idle_n;
      int          pulses;

      a_if.start_i    = 1'b1;
      a_if.seed_sel_i = 2'b00;
      d_if.start_i    = 1'b1;
      d_if.seed_sel_i = 2'b00;
      rst_i           = 1'b1;

      // Reset wins over a held start
      step();
      step();
      chk16("rst_a_rnd", a_if.rnd_o, 16'h0000);
      chk1("rst_a_valid", a_if.valid_o, 1'b0);
      chk1("rst_a_busy", a_if.busy_o, 1'b0);
      chk16("rst_d_rnd", d_if.rnd_o, 16'h0000);
      chk1("rst_d_valid", d_if.valid_o, 1'b0);
      chk1("rst_d_busy", d_if.busy_o, 1'b0);

      a_if.start_i = 1'b0;
      d_if.start_i = 1'b0;
      rst_i        = 1'b0;
      step();
      chk1("idle_a_busy", a_if.busy_o, 1'b0);

      // 0001 -> 0002; (0001^0002) -> 0006
      run_a("a_first", 2'b00, 16'h0002);
      run_a("a_second", 2'b00, 16'h0006);

      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk16("a_rerst_rnd", a_if.rnd_o, 16'h0000);

      // 0002^0002 is zero, so ACE1 is substituted and shifts to 59C3
      run_a("a_sel0", 2'b00, 16'h0002);
      run_a("a_lockup", 2'b01, 16'h59C3);

      // Continuous start: first word after 17 edges, then every 19 cycles
      prev_d          = 16'h0000;
      d_if.start_i    = 1'b1;
      d_if.seed_sel_i = 2'b00;
      step();
      n = 0;
      do begin
         step();
         n++;
      end while (!d_if.valid_o && n < 40);
      exp_w = model(16'hACE1, prev_d, 16);
      chkn("cont_first_latency", n, 17);
      chk16("cont_first_rnd", d_if.rnd_o, exp_w);
      prev_d = exp_w;
      for (int p = 0; p < 3; p++) begin
         n      = 0;
         idle_n = 0;
         do begin
            step();
            n++;
            if (!d_if.busy_o) idle_n++;
         end while (!d_if.valid_o && n < 40);
         exp_w = model(16'hACE1, prev_d, 16);
         chkn("cont_period", n, 19);
         chkn("cont_idle_cycles", idle_n, 1);
         chk16("cont_rnd", d_if.rnd_o, exp_w);
         prev_d = exp_w;
      end
      d_if.start_i = 1'b0;
      step();
      step();
      chk1("cont_stop_busy", d_if.busy_o, 1'b0);
      chk16("cont_rnd_hold", d_if.rnd_o, prev_d);

      // Mid-run seed_sel_i change must not alter the word in progress
      exp_w = model(16'hACE1, prev_d, 16);
      run_d("sel_change", 2'b00, 2'b11, exp_w);
      prev_d = exp_w;

      // Reset during SHIFT (counter at 5) aborts the word
      d_if.start_i    = 1'b1;
      d_if.seed_sel_i = 2'b10;
      step();
      d_if.start_i = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk1("abort_pre_busy", d_if.busy_o, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk1("abort_busy", d_if.busy_o, 1'b0);
      chk1("abort_valid", d_if.valid_o, 1'b0);
      chk16("abort_rnd", d_if.rnd_o, 16'h0000);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (d_if.valid_o) pulses++;
      end
      chkn("abort_no_pulse", pulses, 0);
      chk16("abort_rnd_after", d_if.rnd_o, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rng_lfsr_gen.md
RNG_LFSR_GEN -- requirements
Module: rng_lfsr_gen

Interface
REQ-001 Parameter SEED_0, default 16'hACE1, meaning seed word selected when seed_sel_i = 2'b00.
REQ-002 Parameter SEED_1, default 16'h1D87, meaning seed word selected when seed_sel_i = 2'b01.
REQ-003 Parameter SEED_2, default 16'hB400, meaning seed word selected when seed_sel_i = 2'b10.
REQ-004 Parameter SEED_3, default 16'h5A5A, meaning seed word selected when seed_sel_i = 2'b11.
REQ-005 Parameter ITER_CNT, default 16, meaning number of LFSR shifts per generated word; legal range is 1..255.
REQ-006 Port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port start_i, input, 1 bit: generation request, sampled only in IDLE.
REQ-009 Port seed_sel_i, input, 2 bits: seed index from the upstream seed selector.
REQ-010 Port rnd_o, output, 16 bits: last generated random word, registered.
REQ-011 Port valid_o, output, 1 bit: one-cycle pulse marking a new rnd_o.
REQ-012 Port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE SHALL transition to LOAD on the edge where start_i=1, latching seed_sel_i into an internal 2-bit register; start_i=0 keeps IDLE.
REQ-015 LOAD SHALL set lfsr <= SEED[sel] XOR rnd_o, clear the shift counter to 0, and go to SHIFT.
REQ-016 If SEED[sel] XOR rnd_o equals 16'h0000, LOAD SHALL substitute 16'hACE1 (lock-up avoidance).
REQ-017 Each SHIFT edge SHALL perform lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]} and increment the counter (8-bit).
REQ-018 On the SHIFT edge performing shift number ITER_CNT, the FSM SHALL go to DONE and rnd_o SHALL take the shifted lfsr value on that same edge.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 valid_o SHALL equal (state == DONE); busy_o SHALL equal (state != IDLE).
REQ-021 Latency: with start_i sampled at edge E0, valid_o SHALL be high for exactly the cycle following edge E0+ITER_CNT+1.
REQ-022 start_i SHALL be ignored in LOAD, SHIFT and DONE (no queuing); a start_i high in the DONE cycle has no effect.
REQ-023 seed_sel_i changes after the IDLE->LOAD edge SHALL not affect the word in progress.
REQ-024 rnd_o SHALL hold its value between DONE pulses.
REQ-025 The lfsr SHALL never hold 16'h0000 in SHIFT.

Reset
REQ-026 While rst_i=1 at a rising edge, state SHALL become IDLE, and lfsr, counter, latched sel and rnd_o SHALL become 0.
REQ-027 During reset, valid_o=0 and busy_o=0; rst_i has priority over start_i.
REQ-028 Reset asserted in LOAD/SHIFT/DONE SHALL abort the word with no valid_o pulse; rnd_o reads 16'h0000 afterward.

Verification
REQ-029 Reset: rst_i=1 for 2 cycles, start_i=1 throughout -> rnd_o=16'h0000, valid_o=0, busy_o=0.
REQ-030 ITER_CNT=1, SEED_0=16'h0001, after reset: start with sel=00 -> rnd_o=16'h0002, valid_o high 2 edges after start sampled; a second identical start -> 16'h0006.
REQ-031 ITER_CNT=1, SEED_0=16'h0001, SEED_1=16'h0002: run sel=00 (rnd_o=16'h0002), then sel=01 -> XOR is zero, substitute 16'hACE1 -> rnd_o=16'h59C3.
REQ-032 Default parameters: pulse start_i, then hold start_i=1 continuously -> valid_o pulses every 19 cycles, busy_o low only 1 cycle between runs, each pulse exactly 1 cycle.
REQ-033 Assert rst_i during SHIFT (counter=5) -> next cycle IDLE, busy_o=0, rnd_o=16'h0000, no valid_o pulse.
REQ-034 Change seed_sel_i from 00 to 11 during SHIFT -> rnd_o matches the sel=00 reference model value.
